max7219_sequencer: RTL and testbench

- Command sequencer that drives the 16-bit SPI master feeding the MAX7219 LED display driver.
- After reset it issues the driver's power-up configuration words. It then refreshes the eight digit registers from a snapshotted 64-bit frame on request, or continuously.
- It owns the chip-select/LOAD line and is the only source of start and data_in for the SPI master.

---
 rtl/max7219_sequencer.sv | 168 ++++++++++++++++
 tb/tb_max7219_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_sequencer.sv
// MAX7219 command sequencer: power-up configuration, then 8-digit frame refresh.
// Owns cs_n/LOAD and the start/data handshake toward a 16-bit SPI master.
module max7219_sequencer #(
    parameter logic [2:0] SCAN_LIMIT     = 3'd7,
    parameter logic [7:0] DECODE_MODE    = 8'h00,
    parameter logic [3:0] INTENSITY      = 4'h8,
    parameter bit         AUTO_REFRESH   = 1'b0,
    parameter int         CS_HIGH_CYCLES = 4,
    parameter int         BUSY_TIMEOUT   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        update,
    input  logic [63:0] digit_data,
    output logic        spi_start,
    output logic [15:0] spi_data,
    input  logic        spi_busy,
    output logic        cs_n,
    output logic        init_done,
    output logic        ready,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        INIT_ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        GAP,
        IDLE
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(BUSY_TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST = 16'(CS_HIGH_CYCLES - 1);
    localparam bit          GAP_ONE  = (CS_HIGH_CYCLES == 1);
    localparam logic [15:0] GAP_PRE  =
        16'((CS_HIGH_CYCLES >= 2) ? CS_HIGH_CYCLES - 2 : 0);

    state_t      state;
    logic [2:0]  idx;
    logic        in_frame;
    logic        pending;
    logic [63:0] snap;
    logic [15:0] tmo;
    logic [15:0] gap;
    logic        last_word;
    logic        last_frame;
    logic [2:0]  idx_nxt;

    function automatic logic [15:0] init_word(input logic [2:0] i);
        logic [15:0] w;
        unique case (i)
            3'd0:    w = 16'h0F00;
            3'd1:    w = {8'h0B, 5'b0, SCAN_LIMIT};
            3'd2:    w = {8'h09, DECODE_MODE};
            3'd3:    w = {8'h0A, 4'b0, INTENSITY};
            default: w = 16'h0C01;
        endcase
        return w;
    endfunction

    function automatic logic [15:0] frame_word(
        input logic [2:0]  i,
        input logic [63:0] d
    );
        logic [7:0] addr;
        addr = {5'b0, i} + 8'd1;
        return {addr, d[{i, 3'b000} +: 8]};
    endfunction

    assign last_word  = in_frame ? (idx == 3'd7) : (idx == 3'd4);
    assign last_frame = in_frame && (idx == 3'd7);
    assign idx_nxt    = idx + 3'd1;

    // Word sequencing FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= INIT_ISSUE;
            idx        <= 3'd0;
            in_frame   <= 1'b0;
            pending    <= 1'b0;
            snap       <= 64'h0;
            tmo        <= 16'h0;
            gap        <= 16'h0;
            spi_start  <= 1'b0;
            spi_data   <= 16'h0000;
            cs_n       <= 1'b1;
            init_done  <= 1'b0;
            ready      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            spi_start  <= 1'b0;
            frame_done <= 1'b0;
            if (update && state != IDLE)
                pending <= 1'b1;
            case (state)
                INIT_ISSUE: begin
                    spi_data  <= init_word(idx);
                    spi_start <= 1'b1;
                    cs_n      <= 1'b0;
                    tmo       <= 16'h0;
                    state     <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (spi_busy) begin
                        state <= WAIT_DONE;
                    end else if (tmo == TMO_LAST) begin
                        spi_start <= 1'b1;
                        tmo       <= 16'h0;
                    end else begin
                        tmo <= tmo + 16'h1;
                    end
                end
                WAIT_DONE: begin
                    if (!spi_busy) begin
                        cs_n  <= 1'b1;
                        gap   <= 16'h0;
                        state <= GAP;
                        if (GAP_ONE && last_frame)
                            frame_done <= 1'b1;
                    end
                end
                GAP: begin
                    if (gap == GAP_LAST) begin
                        if (last_word) begin
                            idx      <= 3'd0;
                            in_frame <= 1'b0;
                            state    <= IDLE;
                            ready    <= !(pending || update);
                            if (!in_frame)
                                init_done <= 1'b1;
                        end else begin
                            idx       <= idx_nxt;
                            spi_data  <= in_frame ?
                                frame_word(idx_nxt, snap) :
                                init_word(idx_nxt);
                            spi_start <= 1'b1;
                            cs_n      <= 1'b0;
                            tmo       <= 16'h0;
                            state     <= WAIT_BUSY;
                        end
                    end else begin
                        gap <= gap + 16'h1;
                        if (!GAP_ONE && last_frame && gap == GAP_PRE)
                            frame_done <= 1'b1;
                    end
                end
                IDLE: begin
                    if (update || pending || AUTO_REFRESH) begin
                        pending   <= 1'b0;
                        snap      <= digit_data;
                        in_frame  <= 1'b1;
                        idx       <= 3'd0;
                        spi_data  <= frame_word(3'd0, digit_data);
                        spi_start <= 1'b1;
                        cs_n      <= 1'b0;
                        tmo       <= 16'h0;
                        ready     <= 1'b0;
                        state     <= WAIT_BUSY;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                default: state <= INIT_ISSUE;
            endcase
        end
    end

endmodule

// File: tb/tb_max7219_sequencer.sv
// Directed bench for max7219_sequencer with behavioural SPI master models.
// Covers init words, frames, snapshot, pending coalescing, timeout, reset, auto.
module tb_max7219_sequencer;

    localparam int XFER = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        update;
    logic [63:0] digit_data;
    logic        spi_start;
    logic [15:0] spi_data;
    logic        spi_busy = 1'b0;
    logic        cs_n;
    logic        init_done;
    logic        ready;
    logic        frame_done;

    logic        b_update = 1'b0;
    logic [63:0] b_digits = 64'h8877665544332211;
    logic        b_start;
    logic [15:0] b_data;
    logic        b_busy = 1'b0;
    logic        b_cs_n;
    logic        b_init_done;
    logic        b_ready;
    logic        b_frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    max7219_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .update     (update),
        .digit_data (digit_data),
        .spi_start  (spi_start),
        .spi_data   (spi_data),
        .spi_busy   (spi_busy),
        .cs_n       (cs_n),
        .init_done  (init_done),
        .ready      (ready),
        .frame_done (frame_done)
    );

    max7219_sequencer #(.AUTO_REFRESH(1'b1)) dut_auto (
        .clk        (clk),
        .rst        (rst),
        .update     (b_update),
        .digit_data (b_digits),
        .spi_start  (b_start),
        .spi_data   (b_data),
        .spi_busy   (b_busy),
        .cs_n       (b_cs_n),
        .init_done  (b_init_done),
        .ready      (b_ready),
        .frame_done (b_frame_done)
    );

    // SPI master model A: busy for XFER cycles, can drop one start.
    logic ignore_arm = 1'b0;
    logic ignored = 1'b0;
    int   a_cnt = 0;
    always @(posedge clk) begin
        if (rst) begin
            spi_busy <= 1'b0;
            a_cnt    <= 0;
        end else if (spi_busy) begin
            if (a_cnt == 1) spi_busy <= 1'b0;
            a_cnt <= a_cnt - 1;
        end else if (spi_start) begin
            if (ignore_arm && !ignored) begin
                ignored <= 1'b1;
            end else begin
                spi_busy <= 1'b1;
                a_cnt    <= XFER;
            end
        end
    end

    // SPI master model B.
    int b_cnt = 0;
    always @(posedge clk) begin
        if (rst) begin
            b_busy <= 1'b0;
            b_cnt  <= 0;
        end else if (b_busy) begin
            if (b_cnt == 1) b_busy <= 1'b0;
            b_cnt <= b_cnt - 1;
        end else if (b_start) begin
            b_busy <= 1'b1;
            b_cnt  <= XFER;
        end
    end

    // Monitor A: latched words, gaps, starts, frame_done, protocol violations.
    logic        a_prev_cs = 1'b1;
    int          a_hi = 0;
    bit          a_seen = 1'b0;
    int          a_min_gap = 1000;
    int          a_falls = 0;
    int          a_starts = 0;
    int          a_fd = 0;
    int          a_viol = 0;
    int          a_start_cyc[$];
    logic [15:0] words[$];
    always @(negedge clk) begin
        if (rst) begin
            a_prev_cs = 1'b1;
            a_seen    = 1'b0;
            a_hi      = 0;
        end else begin
            if (spi_start) begin
                a_starts++;
                a_start_cyc.push_back(cyc);
                if (spi_busy || cs_n) a_viol++;
            end
            if (frame_done) a_fd++;
            if (a_prev_cs && !cs_n) begin
                a_falls++;
                if (a_seen && a_hi < a_min_gap) a_min_gap = a_hi;
                a_hi   = 0;
                a_seen = 1'b1;
            end
            if (!a_prev_cs && cs_n) words.push_back(spi_data);
            if (cs_n) a_hi++;
            a_prev_cs = cs_n;
        end
    end

    // Monitor B.
    int b_fd = 0;
    int b_viol = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (b_frame_done) b_fd++;
            if (b_start && (b_busy || b_cs_n)) b_viol++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_update();
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    task automatic wait_words(input int n);
        for (int i = 0; i < 3000 && words.size() < n; i++) tick();
        check("wait_words", 64'(words.size() >= n), 64'd1);
    endtask

    task automatic wait_word_active(input int n);
        for (int i = 0; i < 3000 && !(words.size() >= n && !cs_n); i++)
            tick();
        check("wait_active", 64'(words.size() >= n && !cs_n), 64'd1);
    endtask

    task automatic wait_init();
        for (int i = 0; i < 3000 && !init_done; i++) tick();
        check("wait_init", 64'(init_done), 64'd1);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 3000 && !ready; i++) tick();
        check("wait_ready", 64'(ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [15:0] init_exp [5];
    int          base;
    int          s0;
    int          f0;

    initial begin
        init_exp = '{16'h0F00, 16'h0B07, 16'h0900, 16'h0A08, 16'h0C01};
        rst        = 1'b1;
        update     = 1'b0;
        digit_data = 64'h0807060504030201;
        repeat (3) tick();
        check("rst_start", 64'(spi_start), 64'd0);
        check("rst_data", 64'(spi_data), 64'h0);
        check("rst_cs", 64'(cs_n), 64'd1);
        check("rst_init", 64'(init_done), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_fdone", 64'(frame_done), 64'd0);
        rst = 1'b0;

        wait_word_active(1);
        pulse_update();
        wait_word_active(3);
        pulse_update();
        wait_init();
        check("ready_pending", 64'(ready), 64'd0);
        for (int k = 0; k < 5; k++)
            check("init_word", 64'(words[k]), 64'(init_exp[k]));

        wait_ready();
        for (int k = 0; k < 8; k++)
            check("frame1_word", 64'(words[5 + k]),
                  64'({8'(k + 1), 8'(k + 1)}));
        check("frame1_done", 64'(a_fd), 64'd1);
        repeat (100) tick();
        check("one_frame", 64'(words.size()), 64'd13);
        check("idle_ready", 64'(ready), 64'd1);

        base       = words.size();
        digit_data = 64'h1817161514131211;
        pulse_update();
        check("latency", 64'(spi_start), 64'd1);
        check("ready_busy", 64'(ready), 64'd0);
        wait_words(base + 1);
        digit_data = 64'hFFFFFFFFFFFFFFFF;
        wait_ready();
        for (int k = 0; k < 8; k++)
            check("snap_word", 64'(words[base + k]),
                  64'({8'(k + 1), 8'(8'h11 + k)}));
        check("frame2_done", 64'(a_fd), 64'd2);

        base       = words.size();
        s0         = a_starts;
        f0         = a_falls;
        ignore_arm = 1'b1;
        pulse_update();
        wait_ready();
        for (int k = 0; k < 8; k++)
            check("tmo_word", 64'(words[base + k]),
                  64'({8'(k + 1), 8'hFF}));
        check("tmo_words", 64'(words.size()), 64'(base + 8));
        check("tmo_starts", 64'(a_starts - s0), 64'd9);
        check("tmo_falls", 64'(a_falls - f0), 64'd8);
        check("tmo_delay", 64'(a_start_cyc[s0 + 1] - a_start_cyc[s0]),
              64'd8);
        check("frame3_done", 64'(a_fd), 64'd3);

        base = words.size();
        pulse_update();
        wait_word_active(base + 4);
        rst = 1'b1;
        tick();
        check("mid_rst_start", 64'(spi_start), 64'd0);
        check("mid_rst_data", 64'(spi_data), 64'h0);
        check("mid_rst_cs", 64'(cs_n), 64'd1);
        check("mid_rst_init", 64'(init_done), 64'd0);
        check("mid_rst_ready", 64'(ready), 64'd0);
        rst  = 1'b0;
        base = words.size();
        wait_words(base + 1);
        check("restart_word", 64'(words[base]), 64'h0F00);
        wait_init();
        check("restart_ready", 64'(ready), 64'd1);
        check("restart_last", 64'(words[base + 4]), 64'h0C01);

        repeat (600) tick();
        check("a_viol", 64'(a_viol), 64'd0);
        check("a_gap", 64'(a_min_gap >= 4), 64'd1);
        check("auto_init", 64'(b_init_done), 64'd1);
        check("auto_frames", 64'(b_fd >= 2), 64'd1);
        check("b_viol", 64'(b_viol), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
